pipe_stage_ctrl: RTL and testbench

- Controller for one 62-bit inter-stage pipeline latch in the NPC core (e.g. IF/ID or ID/EX payload).
- Sequences the latch with a valid/ready handshake, plus a one-entry skid register so that in_ready is driven from a register while throughput stays at one transfer per cycle.
- Applies pipeline stall (freeze) and flush (squash) requests from the hazard unit.
- Counts completed output transfers for performance monitoring.

---
 rtl/pipe_stage_if.sv | 18 +
 rtl/pipe_stage_ctrl.sv | 92 +++++++++
 tb/tb_pipe_stage_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/pipe_stage_if.sv
// ---------------------------------------------------------------------
// pipe_stage_if : valid/ready/data stream bundle for pipeline latches
// Rev 1.0
// ---------------------------------------------------------------------
`default_nettype none

interface pipe_stage_if #(
  parameter int DW = 62
) ();
  logic          valid;
  logic          ready;
  logic [DW-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

`default_nettype wire

// File: rtl/pipe_stage_ctrl.sv
// ---------------------------------------------------------------------
// pipe_stage_ctrl : skid-buffered pipeline latch with stall/flush and transfer counter
// Rev 1.0
// ---------------------------------------------------------------------
`default_nettype none

module pipe_stage_ctrl #(
  parameter int DW    = 62,
  parameter int CNT_W = 32
) (
  input  wire logic             clk,
  input  wire logic             rst,
  pipe_stage_if.slave           in_if,
  pipe_stage_if.master          out_if,
  input  wire logic             stall,
  input  wire logic             flush,
  output logic [1:0]            occupancy,
  output logic [CNT_W-1:0]      xfer_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t        state_q;
  logic [DW-1:0] main_q;
  logic [DW-1:0] skid_q;
  logic          full_q;
  logic          in_fire;
  logic          out_fire;

  // full_q mirrors state==TWO so in_ready comes straight from a flop
  assign in_if.ready  = !full_q && !stall && !flush && !rst;
  assign out_if.valid = (state_q != EMPTY) && !stall;
  assign out_if.data  = main_q;
  assign occupancy    = state_q;

  assign in_fire  = in_if.valid && in_if.ready;
  assign out_fire = out_if.valid && out_if.ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= EMPTY;
      full_q   <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
      xfer_cnt <= '0;
    end else if (flush) begin
      state_q <= EMPTY;
      full_q  <= 1'b0;
    end else begin
      if (out_fire) begin
        xfer_cnt <= xfer_cnt + CNT_W'(1);
      end
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_q <= ONE;
            main_q  <= in_if.data;
          end
        end
        ONE: begin
          if (in_fire && !out_fire) begin
            state_q <= TWO;
            full_q  <= 1'b1;
            skid_q  <= in_if.data;
          end else if (in_fire && out_fire) begin
            main_q <= in_if.data;
          end else if (out_fire) begin
            state_q <= EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            state_q <= ONE;
            full_q  <= 1'b0;
            main_q  <= skid_q;
          end
        end
        default: begin
          state_q <= EMPTY;
          full_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_ctrl.sv
// ---------------------------------------------------------------------
// tb_pipe_stage_ctrl : queue-model scoreboard bench, directed plus random traffic
// Rev 1.0
// ---------------------------------------------------------------------
`default_nettype none

module tb_pipe_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iv = 1'b0;
  logic [61:0] d = '0;
  logic        ordy = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;

  logic [1:0]  occ_a;
  logic [31:0] cnt_a;
  logic [1:0]  occ_b;
  logic [3:0]  cnt_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_stage_if #(.DW(62)) in_a ();
  pipe_stage_if #(.DW(62)) out_a ();
  pipe_stage_if #(.DW(62)) in_b ();
  pipe_stage_if #(.DW(62)) out_b ();

  assign in_a.valid  = iv;
  assign in_a.data   = d;
  assign out_a.ready = ordy;
  assign in_b.valid  = iv;
  assign in_b.data   = d;
  assign out_b.ready = ordy;

  pipe_stage_ctrl #(.DW(62), .CNT_W(32)) dut_a (
    .clk(clk), .rst(rst), .in_if(in_a), .out_if(out_a),
    .stall(stall), .flush(flush), .occupancy(occ_a), .xfer_cnt(cnt_a)
  );

  pipe_stage_ctrl #(.DW(62), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .in_if(in_b), .out_if(out_b),
    .stall(stall), .flush(flush), .occupancy(occ_b), .xfer_cnt(cnt_b)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of up to two accepted payloads plus a transfer count.
  logic [61:0] exp_q[$];
  int unsigned exp_cnt = 0;
  bit          fresh = 1'b1;

  always @(negedge clk) begin
    bit exp_ir;
    bit exp_ov;
    exp_ir = (exp_q.size() < 2) && !stall && !flush;
    exp_ov = (exp_q.size() > 0) && !stall;
    if (!rst) begin
      chk("in_ready",  64'(in_a.ready),  64'(exp_ir));
      chk("out_valid", 64'(out_a.valid), 64'(exp_ov));
      chk("occupancy", 64'(occ_a),       64'(exp_q.size()));
      chk("xfer_cnt",  64'(cnt_a),       64'(exp_cnt));
      chk("occ_w4",    64'(occ_b),       64'(exp_q.size()));
      chk("cnt_w4",    64'(cnt_b),       64'(exp_cnt % 16));
      if (exp_q.size() > 0)
        chk("out_data", 64'(out_a.data), 64'(exp_q[0]));
      else if (fresh)
        chk("out_data_rst", 64'(out_a.data), 64'd0);
    end
    if (rst) begin
      exp_q.delete();
      exp_cnt = 0;
      fresh   = 1'b1;
    end else if (flush) begin
      exp_q.delete();
    end else begin
      if (exp_ov && ordy) begin
        void'(exp_q.pop_front());
        exp_cnt++;
      end
      if (exp_ir && iv) begin
        exp_q.push_back(d);
        fresh = 1'b0;
      end
    end
  end

  task automatic step(input logic v, input logic [61:0] dat, input logic r,
                      input logic st, input logic fl, input logic rs);
    @(posedge clk);
    #1;
    iv = v; d = dat; ordy = r; stall = st; flush = fl; rst = rs;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 62'h0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [63:0] rnd;
    for (int i = 0; i < 3; i++) step(1'b0, 62'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(1);
    // single transfer latency
    step(1'b1, 62'h1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    // back-to-back stream
    for (int i = 0; i < 8; i++) step(1'b1, 62'h10 + 62'(i), 1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    // backpressure: fill both entries, hold 0xC off, then drain
    step(1'b1, 62'hA, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 62'hB, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 62'hC, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 62'hC, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 62'hC, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 62'hC, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    // stall while full
    step(1'b1, 62'hA, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 62'hB, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 62'hE, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(3);
    // flush while full, with a simultaneous offer of 0xD
    step(1'b1, 62'hA, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 62'hB, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 62'hD, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(2);
    // reset while full
    step(1'b1, 62'hA, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 62'hB, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 62'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rnd = {$urandom(), $urandom()};
      step(($urandom % 4) != 0, rnd[61:0], ($urandom % 3) != 0,
           ($urandom % 10) == 0, ($urandom % 25) == 0, ($urandom % 300) == 0);
    end
    idle(4);
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
